ts_bus_sequencer: RTL and testbench

- Owns the BDIR/BC/DI bus of the Turbosound-FM block and shares it between two requesters: the Z80 port decoder (#FFFD/#BFFD) and a host-side register-write queue used by the MCU/OSD to program either YM chip directly.
- Expands every access into timed BDIR/BC phases that the Turbosound double-flop synchroniser can sample.
- Host writes run as atomic five-cycle transactions that save and restore the CPU's chip/status/FM selection and its latched register address, so host activity is invisible to Z80 software.

---
 rtl/ts_bus_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_ts_bus_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ts_bus_sequencer.sv
// Shares the Turbosound BDIR/BC/DI bus between Z80 port writes and a host register-write
// FIFO. Every access becomes a DRIVE phase followed by a GAP phase, each HOLD_CYCLES long.
module ts_bus_sequencer #(
    parameter int HOLD_CYCLES = 4,
    parameter int FIFO_AW     = 3
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CPU_WR_ADDR,
    input  logic       CPU_WR_DATA,
    input  logic [7:0] CPU_DI,
    output logic [7:0] CPU_DO,
    output logic       CPU_OVF,
    input  logic       HOST_VALID,
    output logic       HOST_READY,
    input  logic       HOST_CHIP,
    input  logic [7:0] HOST_REG,
    input  logic [7:0] HOST_DATA,
    output logic       TS_BDIR,
    output logic       TS_BC,
    output logic [7:0] TS_DI,
    input  logic [7:0] TS_DO,
    output logic       BUSY
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int HCW   = $clog2(HOLD_CYCLES);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);

    typedef struct packed {
        logic       chip;
        logic [7:0] rg;
        logic [7:0] data;
    } host_req_t;

    typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

    state_t           state;
    host_req_t        fifo_mem [DEPTH];
    host_req_t        head;
    host_req_t        job;
    logic [FIFO_AW:0] wr_ptr, rd_ptr;
    logic             fifo_empty, fifo_full, rdy_en;
    logic             push, pop, cpu_stb, cpu_go;
    logic             pend_vld, pend_is_addr;
    logic [7:0]       pend_data;
    logic             launch_is_addr;
    logic [7:0]       launch_data;
    logic             is_host;
    logic [2:0]       step;
    logic [HCW-1:0]   hcnt;
    logic [2:0]       cpu_sel;
    logic [7:0]       cpu_reg;
    logic [7:0]       rd_hold;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                        (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign head       = fifo_mem[rd_ptr[FIFO_AW-1:0]];

    // A strobe in the same clock as a pending entry replaces it (address strobe wins).
    assign cpu_stb        = CPU_WR_ADDR | CPU_WR_DATA;
    assign launch_is_addr = cpu_stb ? CPU_WR_ADDR : pend_is_addr;
    assign launch_data    = cpu_stb ? CPU_DI : pend_data;
    assign cpu_go         = (state == IDLE) && (cpu_stb || pend_vld);
    assign pop            = (state == IDLE) && !(cpu_stb || pend_vld) && !fifo_empty;
    assign push           = HOST_VALID && HOST_READY;

    // A pop frees the slot in the same clock, so a full FIFO still accepts while draining.
    assign HOST_READY = rdy_en && (!fifo_full || pop);
    assign CPU_DO     = BUSY ? rd_hold : TS_DO;

    // Host step words: {bc, value}. Steps 3 and 4 put back the CPU's selection and address.
    function automatic logic [8:0] host_word(input logic [2:0] s, input host_req_t r,
                                             input logic [2:0] sel, input logic [7:0] creg);
        case (s)
            3'd0:    return {1'b1, 5'b11111, 1'b0, sel[1], r.chip};
            3'd1:    return {1'b1, r.rg};
            3'd2:    return {1'b0, r.data};
            3'd3:    return {1'b1, 5'b11111, sel};
            default: return {1'b1, creg};
        endcase
    endfunction

    always_ff @(posedge CLK) begin
        if (push) fifo_mem[wr_ptr[FIFO_AW-1:0]] <= {HOST_CHIP, HOST_REG, HOST_DATA};
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= IDLE;
            TS_BDIR      <= 1'b0;
            TS_BC        <= 1'b0;
            TS_DI        <= 8'h00;
            BUSY         <= 1'b0;
            CPU_OVF      <= 1'b0;
            rdy_en       <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            pend_vld     <= 1'b0;
            pend_is_addr <= 1'b0;
            pend_data    <= 8'h00;
            cpu_sel      <= 3'b111;
            cpu_reg      <= 8'h00;
            rd_hold      <= 8'h00;
            hcnt         <= '0;
            step         <= 3'd0;
            is_host      <= 1'b0;
            job          <= '0;
        end else begin
            rdy_en  <= 1'b1;
            CPU_OVF <= cpu_stb && pend_vld;
            if (push) wr_ptr <= wr_ptr + 1'b1;

            if (cpu_go) begin
                pend_vld <= 1'b0;
            end else if (cpu_stb) begin
                pend_vld     <= 1'b1;
                pend_is_addr <= CPU_WR_ADDR;
                pend_data    <= CPU_DI;
            end

            case (state)
                IDLE: begin
                    rd_hold <= TS_DO;
                    if (cpu_go) begin
                        state   <= DRIVE;
                        BUSY    <= 1'b1;
                        TS_BDIR <= 1'b1;
                        TS_BC   <= launch_is_addr;
                        TS_DI   <= launch_data;
                        hcnt    <= HOLD_LAST;
                        is_host <= 1'b0;
                        if (launch_is_addr) begin
                            if (launch_data[7:3] == 5'b11111) cpu_sel <= launch_data[2:0];
                            else                              cpu_reg <= launch_data;
                        end
                    end else if (pop) begin
                        state          <= DRIVE;
                        BUSY           <= 1'b1;
                        TS_BDIR        <= 1'b1;
                        {TS_BC, TS_DI} <= host_word(3'd0, head, cpu_sel, cpu_reg);
                        job            <= head;
                        is_host        <= 1'b1;
                        step           <= 3'd0;
                        hcnt           <= HOLD_LAST;
                        rd_ptr         <= rd_ptr + 1'b1;
                    end
                end
                DRIVE: begin
                    if (hcnt == '0) begin
                        state   <= GAP;
                        TS_BDIR <= 1'b0;
                        TS_BC   <= 1'b0;
                        hcnt    <= HOLD_LAST;
                    end else begin
                        hcnt <= hcnt - 1'b1;
                    end
                end
                GAP: begin
                    if (hcnt == '0) begin
                        // Host steps chain without returning to IDLE, so no CPU access can interleave.
                        if (is_host && step != 3'd4) begin
                            state          <= DRIVE;
                            TS_BDIR        <= 1'b1;
                            {TS_BC, TS_DI} <= host_word(step + 3'd1, job, cpu_sel, cpu_reg);
                            step           <= step + 3'd1;
                            hcnt           <= HOLD_LAST;
                        end else begin
                            state <= IDLE;
                            BUSY  <= 1'b0;
                        end
                    end else begin
                        hcnt <= hcnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ts_bus_sequencer.sv
// Bench for ts_bus_sequencer: vector table, directed multi-cycle sequences and random
// traffic, all compared against a job-timeline reference model.
module tb_ts_bus_sequencer;
    localparam int H = 4;

    logic       CLK = 1'b0, RESET = 1'b1;
    logic       CPU_WR_ADDR = 1'b0, CPU_WR_DATA = 1'b0;
    logic [7:0] CPU_DI = 8'h00, CPU_DO;
    logic       CPU_OVF, HOST_READY, TS_BDIR, TS_BC, BUSY;
    logic       HOST_VALID = 1'b0, HOST_CHIP = 1'b0;
    logic [7:0] HOST_REG = 8'h00, HOST_DATA = 8'h00, TS_DI, TS_DO = 8'h00;

    int checks = 0, errors = 0;

    ts_bus_sequencer #(.HOLD_CYCLES(H), .FIFO_AW(3)) dut (
        .CLK(CLK), .RESET(RESET), .CPU_WR_ADDR(CPU_WR_ADDR), .CPU_WR_DATA(CPU_WR_DATA),
        .CPU_DI(CPU_DI), .CPU_DO(CPU_DO), .CPU_OVF(CPU_OVF), .HOST_VALID(HOST_VALID),
        .HOST_READY(HOST_READY), .HOST_CHIP(HOST_CHIP), .HOST_REG(HOST_REG),
        .HOST_DATA(HOST_DATA), .TS_BDIR(TS_BDIR), .TS_BC(TS_BC), .TS_DI(TS_DI),
        .TS_DO(TS_DO), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       wa, wd;
        logic [7:0] di;
        logic       bdir, bc;
        logic [7:0] tsdi;
        logic       busy;
    } vec_t;
    vec_t vt [20];
    logic [8:0] exp_w [5];

    // Reference model: a job is a list of bus words plus a remaining-clock count;
    // bus outputs follow from how far into the job we are.
    int          m_busy = 0, m_total = 0;
    logic [8:0]  m_words [5];
    logic        m_pend = 1'b0, m_pend_addr = 1'b0;
    logic [7:0]  m_pend_d = 8'h00;
    logic [16:0] m_q [$];
    logic [2:0]  m_sel = 3'b111;
    logic [7:0]  m_reg = 8'h00, m_rdh = 8'h00, m_di = 8'h00;
    logic        m_rdy_en = 1'b0, m_ovf = 1'b0, m_bdir = 1'b0, m_bc = 1'b0;
    bit          model_on = 1'b0;

    logic [8:0]  cap [$];
    int          busy_cnt = 0, ovf_cnt = 0;
    bit          pushed = 1'b0;
    logic        prev_bdir = 1'b0;

    function automatic bit m_idle();
        return m_busy == 0;
    endfunction
    function automatic bit m_cpu_go();
        return m_idle() && (CPU_WR_ADDR || CPU_WR_DATA || m_pend);
    endfunction
    function automatic bit m_pop();
        return m_idle() && !m_cpu_go() && m_q.size() > 0;
    endfunction
    function automatic bit m_ready();
        return m_rdy_en && (m_q.size() < 8 || m_pop());
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit stb, go, pop, push;
        logic [16:0] e;
        int el, ph;
        stb  = CPU_WR_ADDR || CPU_WR_DATA;
        go   = m_cpu_go();
        pop  = m_pop();
        push = HOST_VALID && m_ready();
        if (RESET) begin
            m_busy = 0; m_total = 0; m_pend = 0; m_q.delete();
            m_sel = 3'b111; m_reg = 8'h00; m_rdh = 8'h00; m_di = 8'h00;
            m_rdy_en = 0; m_ovf = 0; m_bdir = 0; m_bc = 0;
            return;
        end
        m_ovf = stb && m_pend;
        if (m_idle()) m_rdh = TS_DO;
        if (go) begin
            m_words[0] = stb ? {CPU_WR_ADDR, CPU_DI} : {m_pend_addr, m_pend_d};
            m_pend  = 0;
            m_total = 2 * H;
            m_busy  = m_total;
            if (m_words[0][8]) begin
                if (m_words[0][7:3] == 5'b11111) m_sel = m_words[0][2:0];
                else                             m_reg = m_words[0][7:0];
            end
        end else begin
            if (pop) begin
                e = m_q.pop_front();
                m_words[0] = {1'b1, 5'b11111, 1'b0, m_sel[1], e[16]};
                m_words[1] = {1'b1, e[15:8]};
                m_words[2] = {1'b0, e[7:0]};
                m_words[3] = {1'b1, 5'b11111, m_sel};
                m_words[4] = {1'b1, m_reg};
                m_total = 10 * H;
                m_busy  = m_total;
            end else if (m_busy > 0) begin
                m_busy--;
            end
            if (stb) begin
                m_pend = 1; m_pend_addr = CPU_WR_ADDR; m_pend_d = CPU_DI;
            end
        end
        if (push) m_q.push_back({HOST_CHIP, HOST_REG, HOST_DATA});
        m_rdy_en = 1;
        m_bdir = 0;
        m_bc   = 0;
        if (m_busy > 0) begin
            el = m_total - m_busy;
            ph = el / H;
            if (ph % 2 == 0) begin
                m_bdir = 1;
                m_bc   = m_words[ph / 2][8];
                m_di   = m_words[ph / 2][7:0];
            end
        end
    endtask

    task automatic tick();
        #1;
        pushed = HOST_VALID && HOST_READY;
        if (model_on) begin
            chk("model_host_ready", HOST_READY, m_ready());
            chk("model_cpu_do", CPU_DO, (m_busy > 0) ? m_rdh : TS_DO);
        end
        @(posedge CLK);
        model_edge();
        if (RESET) model_on = 1;
        #1;
        if (model_on) begin
            chk("model_bdir", TS_BDIR, m_bdir);
            chk("model_bc", TS_BC, m_bc);
            chk("model_di", TS_DI, m_di);
            chk("model_busy", BUSY, m_busy > 0);
            chk("model_ovf", CPU_OVF, m_ovf);
        end
        if (TS_BDIR === 1'b1 && prev_bdir !== 1'b1) cap.push_back({TS_BC, TS_DI});
        prev_bdir = TS_BDIR;
        if (BUSY === 1'b1) busy_cnt++;
        if (CPU_OVF === 1'b1) ovf_cnt++;
    endtask

    task automatic host_push(input logic chip, input logic [7:0] rg, input logic [7:0] d);
        HOST_VALID = 1; HOST_CHIP = chip; HOST_REG = rg; HOST_DATA = d;
        tick();
        HOST_VALID = 0;
    endtask

    task automatic cpu_wr(input logic is_addr, input logic [7:0] d);
        CPU_WR_ADDR = is_addr; CPU_WR_DATA = !is_addr; CPU_DI = d;
        tick();
        CPU_WR_ADDR = 0; CPU_WR_DATA = 0;
    endtask

    initial begin
        int w, bad, r;
        for (int i = 0; i < 10; i++) begin
            vt[i]      = '{wa: (i == 0), wd: 1'b0, di: 8'h07, bdir: (i < 4), bc: (i < 4),
                           tsdi: 8'h07, busy: (i < 8)};
            vt[10 + i] = '{wa: 1'b0, wd: (i == 0), di: 8'h5A, bdir: (i < 4), bc: 1'b0,
                           tsdi: 8'h5A, busy: (i < 8)};
        end

        // Reset state
        RESET = 1;
        repeat (3) tick();
        chk("rst_bdir", TS_BDIR, 0);
        chk("rst_bc", TS_BC, 0);
        chk("rst_di", TS_DI, 8'h00);
        chk("rst_ovf", CPU_OVF, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_ready", HOST_READY, 0);
        RESET = 0;
        tick();
        chk("ready_after_reset", HOST_READY, 1);

        // CPU address write 0x07 then data write 0x5A
        for (int i = 0; i < 20; i++) begin
            CPU_WR_ADDR = vt[i].wa; CPU_WR_DATA = vt[i].wd; CPU_DI = vt[i].di;
            tick();
            chk($sformatf("vec%0d_bdir", i), TS_BDIR, vt[i].bdir);
            chk($sformatf("vec%0d_bc", i), TS_BC, vt[i].bc);
            chk($sformatf("vec%0d_di", i), TS_DI, vt[i].tsdi);
            chk($sformatf("vec%0d_busy", i), BUSY, vt[i].busy);
        end
        CPU_WR_ADDR = 0; CPU_WR_DATA = 0;

        // Host job with sel=111, reg=0x07
        cap.delete(); busy_cnt = 0;
        host_push(1'b1, 8'h28, 8'hF0);
        repeat (45) tick();
        exp_w[0] = 9'h1FB; exp_w[1] = 9'h128; exp_w[2] = 9'h0F0; exp_w[3] = 9'h1FF; exp_w[4] = 9'h107;
        chk("host_nwords", cap.size(), 5);
        for (int k = 0; k < 5; k++)
            if (cap.size() > k) chk($sformatf("host_word%0d", k), cap[k], exp_w[k]);
        chk("host_busy_clocks", busy_cnt, 40);

        // CPU strobes during a host job; second one overwrites the first
        cap.delete(); ovf_cnt = 0;
        host_push(1'b0, 8'h07, 8'h38);
        repeat (10) tick();
        cpu_wr(1'b0, 8'h55);
        chk("ovf_first", CPU_OVF, 0);
        repeat (3) tick();
        cpu_wr(1'b0, 8'h66);
        chk("ovf_second", CPU_OVF, 1);
        repeat (45) tick();
        chk("ovf_count", ovf_cnt, 1);
        chk("ovf_nwords", cap.size(), 6);
        if (cap.size() == 6) begin
            chk("ovf_host_w0", cap[0], 9'h1FA);
            chk("ovf_host_w4", cap[4], 9'h107);
            chk("ovf_cpu_word", cap[5], 9'h066);
        end

        // FIFO fill to 8, push at full with simultaneous pop, drain in order
        cap.delete();
        host_push(1'b0, 8'h30, 8'h00);
        tick();
        HOST_VALID = 1;
        for (int k = 0; k < 8; k++) begin
            HOST_REG = 8'(16 + k); HOST_DATA = 8'(k);
            tick();
        end
        chk("fifo_full_ready", HOST_READY, 0);
        HOST_REG = 8'h18; HOST_DATA = 8'h08;
        pushed = 0; w = 0;
        while (!pushed && w < 60) begin tick(); w++; end
        chk("fifo_push_at_full", pushed, 1);
        HOST_VALID = 0;
        chk("fifo_still_full", HOST_READY, 0);
        repeat (9 * 41 + 20) tick();
        chk("fifo_nwords", cap.size(), 50);
        if (cap.size() == 50)
            for (int j = 0; j < 10; j++)
                chk($sformatf("fifo_order%0d", j), cap[5 * j + 1],
                    {1'b1, (j == 0) ? 8'h30 : 8'(15 + j)});

        // Read path holds the pre-job status during a host job
        TS_DO = 8'hA5;
        tick();
        chk("cpu_do_idle", CPU_DO, 8'hA5);
        host_push(1'b1, 8'h01, 8'h02);
        tick();
        TS_DO = 8'h3C;
        bad = 0; w = 0;
        while (BUSY && w < 60) begin
            if (CPU_DO !== 8'hA5) bad++;
            tick(); w++;
        end
        chk("cpu_do_hold", bad, 0);
        chk("cpu_do_job_end", BUSY, 0);
        chk("cpu_do_first_idle", CPU_DO, 8'h3C);

        // Reset in the middle of host step 2
        cpu_wr(1'b1, 8'hFC);
        repeat (9) tick();
        cap.delete();
        host_push(1'b1, 8'h40, 8'h41);
        tick();
        host_push(1'b0, 8'h42, 8'h43);
        host_push(1'b0, 8'h44, 8'h45);
        w = 0;
        while (cap.size() < 3 && w < 60) begin tick(); w++; end
        chk("rst_mid_nwords", cap.size(), 3);
        if (cap.size() == 3) begin
            chk("rst_mid_w0", cap[0], 9'h1F9);
            chk("rst_mid_w2", cap[2], 9'h041);
        end
        RESET = 1;
        tick();
        chk("rst_mid_bdir", TS_BDIR, 0);
        chk("rst_mid_ready", HOST_READY, 0);
        chk("rst_mid_busy", BUSY, 0);
        RESET = 0;
        busy_cnt = 0;
        repeat (10) tick();
        chk("rst_fifo_flushed", busy_cnt, 0);
        cap.delete();
        host_push(1'b0, 8'h50, 8'h51);
        repeat (45) tick();
        chk("rst_restore_nwords", cap.size(), 5);
        if (cap.size() == 5) begin
            chk("rst_restore_sel", cap[3], 9'h1FF);
            chk("rst_restore_reg", cap[4], 9'h100);
        end
        cpu_wr(1'b1, 8'h0E);
        repeat (9) tick();
        cap.delete();
        host_push(1'b0, 8'h52, 8'h53);
        repeat (45) tick();
        chk("rst_new_reg_nwords", cap.size(), 5);
        if (cap.size() == 5) chk("rst_new_reg", cap[4], 9'h10E);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            RESET       = ($urandom_range(0, 599) == 0);
            r           = $urandom_range(0, 99);
            CPU_WR_ADDR = (r < 4);
            CPU_WR_DATA = (r >= 2 && r < 7);
            CPU_DI      = ($urandom_range(0, 3) == 0) ? {5'b11111, 3'($urandom)} : 8'($urandom);
            HOST_VALID  = ($urandom_range(0, 99) < 12);
            HOST_CHIP   = 1'($urandom);
            HOST_REG    = 8'($urandom);
            HOST_DATA   = 8'($urandom);
            TS_DO       = 8'($urandom);
            tick();
        end
        RESET = 0; CPU_WR_ADDR = 0; CPU_WR_DATA = 0; HOST_VALID = 0;
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
